// File: rtl/regfile_dec_np.sv
// regfile_dec_np: MIPS-style register file, two read ports, one write port,
// internal one-hot write-address decoder exposed on WrSel.
// Options: hardwired-zero r0, write-through bypass, registered read outputs.
module regfile_dec_np #(
   parameter int unsigned ADDR_W   = 5,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned ZERO_REG = 1,
   parameter int unsigned BYPASS   = 1,
   parameter int unsigned READ_REG = 0
) (
   input  logic                     Clk,
   input  logic                     Rst_n,
   input  logic [ADDR_W-1:0]        Adr1,
   input  logic [ADDR_W-1:0]        Adr2,
   input  logic [ADDR_W-1:0]        Awr,
   input  logic [DATA_W-1:0]        Din,
   input  logic                     WrEn,
   output logic [DATA_W-1:0]        Dout1,
   output logic [DATA_W-1:0]        Dout2,
   output logic [(1<<ADDR_W)-1:0]   WrSel
);

   localparam int unsigned DEPTH = 1 << ADDR_W;

   logic [DATA_W-1:0] regs_q [DEPTH];
   logic [DATA_W-1:0] regs_d [DEPTH];
   logic [DATA_W-1:0] rd1_c;
   logic [DATA_W-1:0] rd2_c;
   logic              byp_ok;

   // One-hot write-address decode; independent of ZERO_REG
   always_comb begin
      WrSel = '0;
      if (WrEn) WrSel[Awr] = 1'b1;
   end

   // Next register contents: decoded write, r0 protected when hardwired
   always_comb begin
      regs_d = regs_q;
      for (int unsigned i = 0; i < DEPTH; i++) begin
         if (WrSel[i[ADDR_W-1:0]] && !((ZERO_REG != 0) && (i == 0)))
            regs_d[i[ADDR_W-1:0]] = Din;
      end
   end

   // Storage with asynchronous clear
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int unsigned i = 0; i < DEPTH; i++) regs_q[i[ADDR_W-1:0]] <= '0;
      end else begin
         regs_q <= regs_d;
      end
   end

   // Combinational read value per port: zero register, then bypass, then storage
   always_comb begin
      byp_ok = (BYPASS != 0) && WrEn && !((ZERO_REG != 0) && (Awr == '0));
      rd1_c  = regs_q[Adr1];
      rd2_c  = regs_q[Adr2];
      if (byp_ok && (Adr1 == Awr)) rd1_c = Din;
      if (byp_ok && (Adr2 == Awr)) rd2_c = Din;
      if ((ZERO_REG != 0) && (Adr1 == '0)) rd1_c = '0;
      if ((ZERO_REG != 0) && (Adr2 == '0)) rd2_c = '0;
   end

   generate
      if (READ_REG != 0) begin : g_rreg
         logic [DATA_W-1:0] dout1_q, dout1_d;
         logic [DATA_W-1:0] dout2_q, dout2_d;

         // Registered outputs capture this cycle's combinational result
         always_comb begin
            dout1_d = rd1_c;
            dout2_d = rd2_c;
         end

         // Output registers, cleared with the file
         always_ff @(posedge Clk or negedge Rst_n) begin
            if (!Rst_n) begin
               dout1_q <= '0;
               dout2_q <= '0;
            end else begin
               dout1_q <= dout1_d;
               dout2_q <= dout2_d;
            end
         end

         assign Dout1 = dout1_q;
         assign Dout2 = dout2_q;
      end else begin : g_comb
         assign Dout1 = rd1_c;
         assign Dout2 = rd2_c;
      end
   endgenerate

endmodule

// File: tb/tb_regfile_dec_np.sv
// tb_regfile_dec_np: four configurations driven by shared stimulus and
// checked each cycle against an array-based model, plus literal checks.
`timescale 1ns/1ps
module tb_regfile_dec_np;

   localparam int NCFG = 4;
   // Configurations: {ZERO_REG, BYPASS, READ_REG}
   localparam int ZR [NCFG] = '{1, 0, 1, 0};
   localparam int BP [NCFG] = '{1, 0, 1, 0};
   localparam int RR [NCFG] = '{0, 0, 1, 1};

   logic        Clk = 1'b0;
   logic        Rst_n = 1'b0;
   logic [4:0]  Adr1 = '0, Adr2 = '0, Awr = '0;
   logic [31:0] Din = '0;
   logic        WrEn = 1'b0;

   logic [31:0] dout1 [NCFG];
   logic [31:0] dout2 [NCFG];
   logic [31:0] wrsel [NCFG];

   int errors = 0;
   int checks = 0;
   bit run_chk = 0;

   // Model state
   logic [31:0] m   [NCFG][32];
   logic [31:0] eq1 [NCFG];
   logic [31:0] eq2 [NCFG];

   for (genvar k = 0; k < NCFG; k++) begin : g_dut
      regfile_dec_np #(
         .ADDR_W  (5),
         .DATA_W  (32),
         .ZERO_REG(ZR[k]),
         .BYPASS  (BP[k]),
         .READ_REG(RR[k])
      ) u_dut (
         .Clk  (Clk),
         .Rst_n(Rst_n),
         .Adr1 (Adr1),
         .Adr2 (Adr2),
         .Awr  (Awr),
         .Din  (Din),
         .WrEn (WrEn),
         .Dout1(dout1[k]),
         .Dout2(dout2[k]),
         .WrSel(wrsel[k])
      );
   end

   always #5 Clk = ~Clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
      end
   endtask

   // What a read of address a returns right now in configuration k
   function automatic logic [31:0] comb_rd(input int k, input logic [4:0] a);
      if (ZR[k] != 0 && a == 5'd0) return 32'h0;
      if (BP[k] != 0 && WrEn && a == Awr && !(ZR[k] != 0 && Awr == 5'd0)) return Din;
      return m[k][a];
   endfunction

   function automatic logic [31:0] fillval(input int i);
      return (i == 0) ? 32'h0 : i * 32'h01010101;
   endfunction

   initial begin
      for (int k = 0; k < NCFG; k++) begin
         for (int i = 0; i < 32; i++) m[k][i] = '0;
         eq1[k] = '0;
         eq2[k] = '0;
      end
   end

   // Model: capture registered read values from pre-edge state, then write
   always @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         for (int k = 0; k < NCFG; k++) begin
            for (int i = 0; i < 32; i++) m[k][i] = '0;
            eq1[k] = '0;
            eq2[k] = '0;
         end
      end else begin
         for (int k = 0; k < NCFG; k++) begin
            eq1[k] = comb_rd(k, Adr1);
            eq2[k] = comb_rd(k, Adr2);
            if (WrEn && !(ZR[k] != 0 && Awr == 5'd0)) m[k][Awr] = Din;
         end
      end
   end

   // Per-cycle comparison mid-cycle
   always @(negedge Clk) begin
      if (run_chk) begin
         for (int k = 0; k < NCFG; k++) begin
            check($sformatf("cfg%0d_dout1", k), dout1[k], (RR[k] != 0) ? eq1[k] : comb_rd(k, Adr1));
            check($sformatf("cfg%0d_dout2", k), dout2[k], (RR[k] != 0) ? eq2[k] : comb_rd(k, Adr2));
            check($sformatf("cfg%0d_wrsel", k), wrsel[k], WrEn ? (32'h1 << Awr) : 32'h0);
         end
      end
   end

   task automatic set(input logic we, input logic [4:0] aw, input logic [31:0] d,
                      input logic [4:0] a1, input logic [4:0] a2);
      @(posedge Clk);
      #1;
      WrEn = we; Awr = aw; Din = d; Adr1 = a1; Adr2 = a2;
   endtask

   initial begin
      repeat (2) @(posedge Clk);
      #1;
      Rst_n = 1'b1;
      run_chk = 1;
      #1;
      for (int k = 0; k < NCFG; k++) begin
         check($sformatf("reset_cfg%0d_d1", k), dout1[k], 32'h0);
         check($sformatf("reset_cfg%0d_d2", k), dout2[k], 32'h0);
      end

      // Decoder sweep
      for (int a = 0; a < 32; a++) begin
         set(1'b1, a[4:0], $urandom, 5'd0, 5'd0);
         #1 check("dec_sweep", wrsel[0], 32'h1 << a);
      end
      set(1'b0, 5'd3, 32'h0, 5'd0, 5'd0);
      #1 check("dec_off", wrsel[0], 32'h0);

      // Asynchronous reset between edges
      set(1'b1, 5'd5, 32'hDEADBEEF, 5'd5, 5'd5);
      set(1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
      #1 check("r5_written", dout1[0], 32'hDEADBEEF);
      Rst_n = 1'b0;
      #1;
      for (int k = 0; k < NCFG; k++) check($sformatf("async_clr_cfg%0d", k), dout1[k], 32'h0);
      Rst_n = 1'b1;

      // Write attempted while reset is held
      set(1'b1, 5'd7, 32'h1234, 5'd7, 5'd7);
      Rst_n = 1'b0;
      repeat (2) @(posedge Clk);
      set(1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
      Rst_n = 1'b1;
      #1;
      check("r7_blocked_cfg0", dout1[0], 32'h0);
      check("r7_blocked_cfg1", dout1[1], 32'h0);

      // Zero register
      set(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
      #1;
      check("zero_pre_cfg0", dout1[0], 32'h0);
      check("zero_pre_cfg1", dout1[1], 32'h0);
      set(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      check("zero_post_cfg0", dout1[0], 32'h0);
      check("zero_post_cfg1", dout1[1], 32'hFFFFFFFF);

      // Bypass
      set(1'b1, 5'd9, 32'h11, 5'd9, 5'd9);
      set(1'b1, 5'd9, 32'h22, 5'd9, 5'd9);
      #1;
      check("byp_cfg0_d1", dout1[0], 32'h22);
      check("byp_cfg0_d2", dout2[0], 32'h22);
      check("nobyp_cfg1_d1", dout1[1], 32'h11);
      check("nobyp_cfg1_d2", dout2[1], 32'h11);
      set(1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
      #1;
      check("nobyp_post_cfg1", dout1[1], 32'h22);
      check("rreg_byp_cfg2", dout1[2], 32'h22);
      check("rreg_nobyp_cfg3", dout1[3], 32'h11);

      // Registered read latency
      set(1'b1, 5'd3, 32'hA5A5A5A5, 5'd0, 5'd0);
      set(1'b1, 5'd4, 32'h5A5A5A5A, 5'd0, 5'd0);
      set(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
      #1;
      check("rreg_old_cfg2_d1", dout1[2], 32'h0);
      check("rreg_old_cfg2_d2", dout2[2], 32'h0);
      check("rreg_old_cfg3_d1", dout1[3], 32'hFFFFFFFF);
      set(1'b0, 5'd0, 32'h0, 5'd3, 5'd4);
      #1;
      check("rreg_new_cfg2_d1", dout1[2], 32'hA5A5A5A5);
      check("rreg_new_cfg2_d2", dout2[2], 32'h5A5A5A5A);
      check("rreg_new_cfg3_d2", dout2[3], 32'h5A5A5A5A);

      // Full fill and readback
      for (int i = 1; i < 32; i++) set(1'b1, i[4:0], fillval(i), 5'd0, 5'd0);
      for (int i = 0; i < 32; i++) begin
         set(1'b0, 5'd0, 32'h0, i[4:0], 5'(31 - i));
         #1;
         check("fill_d1", dout1[0], fillval(i));
         check("fill_d2", dout2[0], fillval(31 - i));
      end

      // Randomized traffic with address collisions and occasional async reset
      for (int n = 0; n < 400; n++) begin
         logic [4:0] aw, a1, a2;
         aw = 5'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom);
         a2 = ($urandom_range(0, 3) == 0) ? aw : 5'($urandom);
         set(1'($urandom_range(0, 3) != 0), aw, $urandom, a1, a2);
         if ($urandom_range(0, 39) == 0) begin
            #1 Rst_n = 1'b0;
            #1 Rst_n = 1'b1;
         end
      end

      @(posedge Clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
